morra_scoreboard: RTL and testbench

- Downstream consumer of the Morra Cinese game FSM.
- Samples the per-cycle ROUND and GAME codes and keeps per-game round statistics.
- Latches each finished game's result, holds it for display for a fixed time, and accumulates session-wide match tallies.
- Feeds the board display / LED driver stage.

---
 rtl/morra_scoreboard_if.sv | 35 +++
 rtl/morra_scoreboard.sv | 126 ++++++++++++
 tb/tb_morra_scoreboard.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/morra_scoreboard_if.sv
// Morra scoreboard bus: game FSM codes in, round/match statistics out.
// The master side drives START/ROUND/GAME; the slave side is the scoreboard.
interface morra_scoreboard_if #(
  parameter int CNT_W   = 4,
  parameter int TALLY_W = 8
);
  logic               START;
  logic [1:0]         ROUND;
  logic [1:0]         GAME;
  logic [CNT_W-1:0]   P1_ROUNDS;
  logic [CNT_W-1:0]   P2_ROUNDS;
  logic [CNT_W-1:0]   TIE_ROUNDS;
  logic [CNT_W-1:0]   NULL_ROUNDS;
  logic [TALLY_W-1:0] P1_MATCHES;
  logic [TALLY_W-1:0] P2_MATCHES;
  logic [TALLY_W-1:0] DRAW_MATCHES;
  logic [1:0]         RESULT;
  logic               RESULT_VALID;
  logic               SHOW;
  logic               BUSY;

  modport master (
    output START, ROUND, GAME,
    input  P1_ROUNDS, P2_ROUNDS, TIE_ROUNDS, NULL_ROUNDS,
    input  P1_MATCHES, P2_MATCHES, DRAW_MATCHES,
    input  RESULT, RESULT_VALID, SHOW, BUSY
  );

  modport slave (
    input  START, ROUND, GAME,
    output P1_ROUNDS, P2_ROUNDS, TIE_ROUNDS, NULL_ROUNDS,
    output P1_MATCHES, P2_MATCHES, DRAW_MATCHES,
    output RESULT, RESULT_VALID, SHOW, BUSY
  );
endinterface

// File: rtl/morra_scoreboard.sv
// Morra scoreboard: per-game round counters, result hold and
// session-wide saturating match tallies fed from the game FSM codes.
module morra_scoreboard #(
  parameter int CNT_W       = 4,
  parameter int TALLY_W     = 8,
  parameter int HOLD_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  morra_scoreboard_if.slave bus
);

  localparam int TMR_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAYING,
    S_HOLD
  } state_t;

  state_t             state;
  logic [TMR_W-1:0]   tmr;
  logic [CNT_W-1:0]   p1_q;
  logic [CNT_W-1:0]   p2_q;
  logic [CNT_W-1:0]   tie_q;
  logic [CNT_W-1:0]   nul_q;
  logic [TALLY_W-1:0] m1_q;
  logic [TALLY_W-1:0] m2_q;
  logic [TALLY_W-1:0] md_q;
  logic [1:0]         res_q;
  logic               rv_q;
  logic               show_q;
  logic               busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      tmr    <= '0;
      p1_q   <= '0;
      p2_q   <= '0;
      tie_q  <= '0;
      nul_q  <= '0;
      m1_q   <= '0;
      m2_q   <= '0;
      md_q   <= '0;
      res_q  <= '0;
      rv_q   <= 1'b0;
      show_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      if (bus.START) begin
        state  <= S_PLAYING;
        tmr    <= '0;
        p1_q   <= '0;
        p2_q   <= '0;
        tie_q  <= '0;
        nul_q  <= '0;
        show_q <= 1'b0;
        busy_q <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
          end
          S_PLAYING: begin
            if (bus.GAME != 2'b00) begin
              // game over: latch, tally, freeze display
              res_q  <= bus.GAME;
              rv_q   <= 1'b1;
              state  <= S_HOLD;
              tmr    <= TMR_W'(HOLD_CYCLES);
              show_q <= 1'b1;
              busy_q <= 1'b0;
              unique case (bus.GAME)
                2'b01: if (m1_q != '1) m1_q <= m1_q + TALLY_W'(1);
                2'b10: if (m2_q != '1) m2_q <= m2_q + TALLY_W'(1);
                2'b11: if (md_q != '1) md_q <= md_q + TALLY_W'(1);
                default: begin
                end
              endcase
            end else begin
              unique case (bus.ROUND)
                2'b00: if (nul_q != '1) nul_q <= nul_q + CNT_W'(1);
                2'b01: if (p1_q != '1) p1_q <= p1_q + CNT_W'(1);
                2'b10: if (p2_q != '1) p2_q <= p2_q + CNT_W'(1);
                2'b11: if (tie_q != '1) tie_q <= tie_q + CNT_W'(1);
              endcase
            end
          end
          S_HOLD: begin
            if (tmr == TMR_W'(1)) begin
              state  <= S_PLAYING;
              tmr    <= '0;
              p1_q   <= '0;
              p2_q   <= '0;
              tie_q  <= '0;
              nul_q  <= '0;
              show_q <= 1'b0;
              busy_q <= 1'b1;
            end else begin
              tmr <= tmr - TMR_W'(1);
            end
          end
          default: begin
            state  <= S_IDLE;
            show_q <= 1'b0;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.P1_ROUNDS    = p1_q;
  assign bus.P2_ROUNDS    = p2_q;
  assign bus.TIE_ROUNDS   = tie_q;
  assign bus.NULL_ROUNDS  = nul_q;
  assign bus.P1_MATCHES   = m1_q;
  assign bus.P2_MATCHES   = m2_q;
  assign bus.DRAW_MATCHES = md_q;
  assign bus.RESULT       = res_q;
  assign bus.RESULT_VALID = rv_q;
  assign bus.SHOW         = show_q;
  assign bus.BUSY         = busy_q;

endmodule

// File: tb/tb_morra_scoreboard.sv
// Directed bench for morra_scoreboard with a cycle-level reference
// model and literal checkpoints from the game scenarios.
module tb_morra_scoreboard;

  localparam int CNT_W   = 4;
  localparam int TALLY_W = 8;
  localparam int HOLD    = 8;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int TMAX    = (1 << TALLY_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  morra_scoreboard_if #(.CNT_W(CNT_W), .TALLY_W(TALLY_W)) bus ();

  morra_scoreboard #(
    .CNT_W(CNT_W),
    .TALLY_W(TALLY_W),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  bit chk_on = 1'b0;

  // reference model state
  int r_p1, r_p2, r_tie, r_nul;
  int m_p1, m_p2, m_dr;
  int res, rv;
  int started;
  int hold_left;

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_reset();
    r_p1 = 0; r_p2 = 0; r_tie = 0; r_nul = 0;
    m_p1 = 0; m_p2 = 0; m_dr = 0;
    res = 0; rv = 0; started = 0; hold_left = 0;
  endtask

  task automatic model_clear_rounds();
    r_p1 = 0; r_p2 = 0; r_tie = 0; r_nul = 0;
  endtask

  task automatic model_step(input bit st, input int rnd, input int gm);
    rv = 0;
    if (st) begin
      started = 1;
      hold_left = 0;
      model_clear_rounds();
    end else if (started == 0) begin
    end else if (hold_left > 0) begin
      if (hold_left == 1) model_clear_rounds();
      hold_left = hold_left - 1;
    end else if (gm != 0) begin
      res = gm;
      rv = 1;
      hold_left = HOLD;
      if (gm == 1) m_p1 = sat(m_p1, TMAX);
      if (gm == 2) m_p2 = sat(m_p2, TMAX);
      if (gm == 3) m_dr = sat(m_dr, TMAX);
    end else begin
      if (rnd == 0) r_nul = sat(r_nul, CMAX);
      if (rnd == 1) r_p1 = sat(r_p1, CMAX);
      if (rnd == 2) r_p2 = sat(r_p2, CMAX);
      if (rnd == 3) r_tie = sat(r_tie, CMAX);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("p1_rounds", int'(bus.P1_ROUNDS), r_p1);
      check("p2_rounds", int'(bus.P2_ROUNDS), r_p2);
      check("tie_rounds", int'(bus.TIE_ROUNDS), r_tie);
      check("null_rounds", int'(bus.NULL_ROUNDS), r_nul);
      check("p1_matches", int'(bus.P1_MATCHES), m_p1);
      check("p2_matches", int'(bus.P2_MATCHES), m_p2);
      check("draw_matches", int'(bus.DRAW_MATCHES), m_dr);
      check("result", int'(bus.RESULT), res);
      check("result_valid", int'(bus.RESULT_VALID), rv);
      check("show", int'(bus.SHOW), (hold_left > 0) ? 1 : 0);
      check("busy", int'(bus.BUSY),
            (started != 0 && hold_left == 0) ? 1 : 0);
    end
  end

  // drive at negedge, advance model at posedge, return at next negedge
  task automatic step(input bit st, input int rnd, input int gm);
    bus.START = st;
    bus.ROUND = 2'(rnd);
    bus.GAME  = 2'(gm);
    @(posedge clk);
    model_step(st, rnd, gm);
    @(negedge clk);
  endtask

  initial begin
    bus.START = 1'b0;
    bus.ROUND = 2'b00;
    bus.GAME  = 2'b00;
    model_reset();
    #1 rst = 1'b1;
    #1 chk_on = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // idle: nothing counted before START
    for (int i = 0; i < 3; i++) step(1'b0, 1, 0);
    check("idle_p1", int'(bus.P1_ROUNDS), 0);
    check("idle_busy", int'(bus.BUSY), 0);

    step(1'b1, 0, 0);
    step(1'b0, 1, 0);
    step(1'b0, 2, 0);
    step(1'b0, 3, 0);
    step(1'b0, 0, 0);
    step(1'b0, 1, 0);
    check("seq_p1", int'(bus.P1_ROUNDS), 2);
    check("seq_p2", int'(bus.P2_ROUNDS), 1);
    check("seq_tie", int'(bus.TIE_ROUNDS), 1);
    check("seq_null", int'(bus.NULL_ROUNDS), 1);
    check("seq_busy", int'(bus.BUSY), 1);

    // P2 wins game; ROUND in that cycle not counted
    step(1'b0, 1, 2);
    check("end_p1", int'(bus.P1_ROUNDS), 2);
    check("end_result", int'(bus.RESULT), 2);
    check("end_rv", int'(bus.RESULT_VALID), 1);
    check("end_p2m", int'(bus.P2_MATCHES), 1);
    check("end_show", int'(bus.SHOW), 1);
    for (int i = 0; i < HOLD - 1; i++) begin
      step(1'b0, 1, 0);
      check("hold_show", int'(bus.SHOW), 1);
      check("hold_rv", int'(bus.RESULT_VALID), 0);
    end
    step(1'b0, 1, 0);
    check("post_show", int'(bus.SHOW), 0);
    check("post_busy", int'(bus.BUSY), 1);
    check("post_p1", int'(bus.P1_ROUNDS), 0);

    // GAME=01 held for 3 cycles: tallied once
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1);
    check("multi_p1m", int'(bus.P1_MATCHES), 1);
    for (int i = 0; i < HOLD - 2; i++) step(1'b0, 0, 0);
    check("multi_busy", int'(bus.BUSY), 1);

    // START beats GAME
    step(1'b1, 0, 3);
    check("sg_draw", int'(bus.DRAW_MATCHES), 0);
    check("sg_rv", int'(bus.RESULT_VALID), 0);
    check("sg_result", int'(bus.RESULT), 1);
    check("sg_busy", int'(bus.BUSY), 1);

    for (int i = 0; i < 20; i++) step(1'b0, 3, 0);
    check("sat_tie", int'(bus.TIE_ROUNDS), 15);

    // enter HOLD, then async reset mid-cycle
    step(1'b0, 0, 1);
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    check("pre_rst_show", int'(bus.SHOW), 1);
    check("pre_rst_p1m", int'(bus.P1_MATCHES), 2);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("rst_show", int'(bus.SHOW), 0);
    check("rst_result", int'(bus.RESULT), 0);
    check("rst_p1m", int'(bus.P1_MATCHES), 0);
    check("rst_p2m", int'(bus.P2_MATCHES), 0);
    check("rst_tie", int'(bus.TIE_ROUNDS), 0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1, 0);
    step(1'b0, 1, 0);
    chk_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
